// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and controller state type for the ahb_lite_master slice.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Encoding is {addr-phase valid, data-phase valid}.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DATA      = 2'b01,
    ST_ADDR      = 2'b10,
    ST_ADDR_DATA = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/ahb_lite_lane_align.sv
// Combinational byte-lane steering: replicates sub-word write data, extracts sub-word read data.
// Zero latency; no flow control of its own.
module ahb_lite_lane_align
  import ahb_lite_pkg::*;
(
  input  logic [2:0]  wr_size_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] wr_data_o,
  input  logic [2:0]  rd_size_i,
  input  logic [1:0]  rd_lane_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_data_o
);

  always_comb begin
    wr_data_o = wr_data_i;
    case (wr_size_i)
      HSIZE_BYTE: wr_data_o = {4{wr_data_i[7:0]}};
      HSIZE_HALF: wr_data_o = {2{wr_data_i[15:0]}};
      default:    wr_data_o = wr_data_i;
    endcase
  end

  always_comb begin
    rd_data_o = rd_data_i;
    case (rd_size_i)
      HSIZE_BYTE: rd_data_o = {24'h0, rd_data_i[{rd_lane_i, 3'b000} +: 8]};
      HSIZE_HALF: rd_data_o = {16'h0, rd_data_i[{rd_lane_i[1], 4'b0000} +: 16]};
      default:    rd_data_o = rd_data_i;
    endcase
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master, address/data pipelined; response 2 cycles + wait states after accept.
// req_ready = !a_vld || HREADY; responses never stall. Option: AHB_LITE_MASTER_LANE_ALIGN_EN.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic                   req_write,
  input  logic [2:0]             req_size,
  input  logic [HDATA_WIDTH-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [HDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [HADDR_WIDTH-1:0] HADDR,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HSIZE,
  output logic                   HWRITE,
  output logic [HDATA_WIDTH-1:0] HWDATA,
  output logic [2:0]             HBURST,
  output logic                   HMASTLOCK,
  output logic [3:0]             HPROT,
  input  logic [HDATA_WIDTH-1:0] HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP
);

  ctrl_state_e state_q, state_d;
  logic a_vld, d_vld, accept, a_adv, a_nxt, d_nxt;

  logic [HADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [2:0]             a_size_q, a_size_d;
  logic                   a_write_q, a_write_d;
  logic [HDATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
  logic                   d_write_q, d_write_d;
  logic [HDATA_WIDTH-1:0] d_wdata_q, d_wdata_d;

  logic [HDATA_WIDTH-1:0] req_wdata_al;
  logic [HDATA_WIDTH-1:0] rd_data;

  assign a_vld  = (state_q == ST_ADDR) || (state_q == ST_ADDR_DATA);
  assign d_vld  = (state_q == ST_DATA) || (state_q == ST_ADDR_DATA);
  assign req_ready = !a_vld || HREADY;
  assign accept = req_valid && req_ready;
  assign a_adv  = a_vld && HREADY;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      a_addr_q  <= '0;
      a_size_q  <= '0;
      a_write_q <= 1'b0;
      a_wdata_q <= '0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      a_addr_q  <= a_addr_d;
      a_size_q  <= a_size_d;
      a_write_q <= a_write_d;
      a_wdata_q <= a_wdata_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
    end
  end

  always_comb begin
    a_nxt     = accept || (a_vld && !HREADY);
    d_nxt     = HREADY ? a_vld : d_vld;
    state_d   = state_q;
    a_addr_d  = a_addr_q;
    a_size_d  = a_size_q;
    a_write_d = a_write_q;
    a_wdata_d = a_wdata_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;

    case ({a_nxt, d_nxt})
      2'b00:   state_d = ST_IDLE;
      2'b01:   state_d = ST_DATA;
      2'b10:   state_d = ST_ADDR;
      default: state_d = ST_ADDR_DATA;
    endcase

    if (accept) begin
      a_addr_d  = req_addr;
      a_size_d  = req_size;
      a_write_d = req_write;
      a_wdata_d = req_wdata_al;
    end

    // HWDATA only changes when a write enters its data phase.
    if (a_adv) begin
      d_write_d = a_write_q;
      if (a_write_q) d_wdata_d = a_wdata_q;
    end
  end

`ifdef AHB_LITE_MASTER_LANE_ALIGN_EN
  logic [2:0] d_size_q, d_size_d;
  logic [1:0] d_lane_q, d_lane_d;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_size_q <= '0;
      d_lane_q <= '0;
    end else begin
      d_size_q <= d_size_d;
      d_lane_q <= d_lane_d;
    end
  end

  always_comb begin
    d_size_d = d_size_q;
    d_lane_d = d_lane_q;
    if (a_adv) begin
      d_size_d = a_size_q;
      d_lane_d = a_addr_q[1:0];
    end
  end

  ahb_lite_lane_align u_lane_align (
    .wr_size_i (req_size),
    .wr_data_i (req_wdata),
    .wr_data_o (req_wdata_al),
    .rd_size_i (d_size_q),
    .rd_lane_i (d_lane_q),
    .rd_data_i (HRDATA),
    .rd_data_o (rd_data)
  );
`else
  assign req_wdata_al = req_wdata;
  assign rd_data      = HRDATA;
`endif

  assign HADDR     = a_addr_q;
  assign HTRANS    = a_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSIZE     = a_size_q;
  assign HWRITE    = a_write_q;
  assign HWDATA    = d_wdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_DEFAULT;

  assign rsp_valid = d_vld && HREADY;
  assign rsp_rdata = (rsp_valid && !d_write_q) ? rd_data : '0;
  assign rsp_err   = rsp_valid && HRESP;

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 The block SHALL have parameter HADDR_WIDTH, default 32, meaning bus address width.
REQ-002 The block SHALL have parameter HDATA_WIDTH, default 32, meaning bus data width; only 32 is supported.
REQ-003 HCLK  in  1  the only clock; all state changes on its rising edge.
REQ-004 HRESET  in  1  asynchronous, active-high reset.
REQ-005 req_valid in 1, req_ready out 1, req_addr in HADDR_WIDTH, req_write in 1, req_size in 3, req_wdata in 32  request port; accepted when req_valid && req_ready.
REQ-006 rsp_valid out 1, rsp_rdata out 32, rsp_err out 1  response port; one-cycle pulse per accepted request, with no backpressure.
REQ-007 HADDR out HADDR_WIDTH, HTRANS out 2, HSIZE out 3, HWRITE out 1, HWDATA out 32  AHB-Lite master outputs.
REQ-008 HBURST out 3 is constant SINGLE (000); HMASTLOCK out 1 is constant 0; HPROT out 4 is constant 0011.
REQ-009 HRDATA in 32, HREADY in 1, HRESP in 1  AHB-Lite responses from the interconnect.

Function
REQ-010 The block SHALL implement a two-stage pipeline consisting of an address-phase register (a_vld, addr, size, write, wdata) and a data-phase register (d_vld, write, wdata).
REQ-011 The block SHALL drive req_ready = !a_vld || HREADY, combinationally.
REQ-012 On acceptance, the request SHALL load into the address-phase register, and HTRANS=NONSEQ SHALL appear in the next cycle; with no accepted request and either the address phase empty or it completing, the next HTRANS SHALL be IDLE (00).
REQ-013 While a_vld && !HREADY, HADDR, HTRANS, HSIZE and HWRITE SHALL be held stable, and the transfer SHALL NOT be cancelled.
REQ-014 When a_vld && HREADY, the address-phase contents SHALL move to the data-phase register in the same edge, so that address N+1 overlaps data N.
REQ-015 HWDATA SHALL be driven from the data-phase wdata for the whole data phase.
REQ-016 HWDATA SHALL be held when no write is in the data phase.
REQ-017 When d_vld && HREADY, the block SHALL assert rsp_valid=1 in the same cycle, with rsp_rdata=HRDATA (reads) or 0 (writes) and rsp_err=HRESP.
REQ-018 After the completion in REQ-017, d_vld SHALL clear unless it is refilled by REQ-014.
REQ-019 When HRESP=1 && HREADY=0 (first cycle of an error), the block SHALL keep the pending address phase unchanged.
REQ-020 When the error completes on the second cycle, the block SHALL report rsp_err=1 for that transfer and then continue normally.
REQ-021 Throughput SHALL be one transfer per cycle with zero wait states.
REQ-022 Request-to-response latency SHALL be 2 cycles plus the number of wait states.
REQ-023 req_size values 3..7 SHALL be forwarded to HSIZE unchanged; address alignment is the requester's responsibility.
REQ-024 The controller states SHALL be defined as IDLE (!a_vld && !d_vld), ADDR (a_vld only), DATA (d_vld only) and ADDR_DATA (both); all transitions follow from REQ-012/014/018.

Reset
REQ-025 While HRESET is high: a_vld=0, d_vld=0, HTRANS=IDLE, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
REQ-026 Reset asserted mid-transfer SHALL drop all in-flight requests without a response.
REQ-027 After reset deasserts, the first HTRANS=NONSEQ SHALL be no earlier than the cycle after the first acceptance.

Configuration
REQ-028 With AHB_LITE_MASTER_LANE_ALIGN_EN defined, sub-word writes SHALL replicate req_wdata[7:0] (size 0) or req_wdata[15:0] (size 1) across all lanes of HWDATA.
REQ-029 With AHB_LITE_MASTER_LANE_ALIGN_EN defined, sub-word reads SHALL return in rsp_rdata the addressed byte or halfword (selected by the data-phase addr[1:0]) right-justified and zero-extended.
REQ-030 Without AHB_LITE_MASTER_LANE_ALIGN_EN, req_wdata and HRDATA SHALL pass unchanged, and addr SHALL NOT be stored in the data phase.

Structure
REQ-031 Package ahb_lite_pkg SHALL hold the HTRANS codes (IDLE=00, NONSEQ=10), the HSIZE codes (BYTE=0, HALF=1, WORD=2), HBURST_SINGLE and HPROT_DEFAULT=0011.
REQ-032 Lane handling SHALL be in the combinational sub-module ahb_lite_lane_align, instantiated only under AHB_LITE_MASTER_LANE_ALIGN_EN.

Verification
REQ-033 Write 0x0000_0010 <- 0xDEADBEEF, then read 0x10, with zero wait states: NONSEQ in consecutive cycles, rsp_valid on cycles 2 and 3, read rsp_rdata=0xDEADBEEF.
REQ-034 Read with HREADY=0 for 3 cycles: HADDR of the pipelined next request held for 3 cycles, rsp_valid exactly once, latency 5.
REQ-035 Slave error sequence HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on a write to 0x20, with a read to 0x24 queued: rsp_err=1 for 0x20, the 0x24 read still issued and completed with rsp_err=0.
REQ-036 HRESET pulsed while in ADDR_DATA: HTRANS=IDLE immediately, no rsp_valid, req_ready=1.
REQ-037 With AHB_LITE_MASTER_LANE_ALIGN_EN, byte write 0xA5 at 0x3 gives HWDATA=0xA5A5A5A5; byte read at 0x2 with HRDATA=0x11223344 gives rsp_rdata=0x00000022.
REQ-038 Back-to-back stream of 8 requests with random HREADY stalls: responses arrive in order, count 8, no HTRANS change during a stall.
